alu_accum_seq: RTL and testbench

Sequencer and initiator that drives the team's 8-bit add/subtract accumulator. It turns one start request into the cycle-by-cycle B/E/S control sequence for ADD, SUB, MUL and DIV. MUL uses repeated add; DIV uses repeated subtract with a quotient count. It reads the accumulator output back, captures result and remainder, and pulses done. It sits between an operation issuer and the accumulator.

---
 rtl/alu_accum_seq_pkg.sv | 21 ++
 rtl/alu_accum_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_accum_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_accum_seq_pkg.sv
// Shared encodings for the accumulator sequencer: operation codes and FSM states.
package alu_accum_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_OPB    = 3'd3,
    ST_MUL_IT = 3'd4,
    ST_DIV_IT = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/alu_accum_seq.sv
// Drives an external add/sub accumulator through ADD/SUB/MUL/DIV sequences; latency 4, 3+a, 4+quot, 1 (div0).
// No backpressure: start is only sampled in IDLE and is dropped, never queued, while busy.
module alu_accum_seq
  import alu_accum_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] acc_b,
  output logic             acc_e,
  output logic             acc_s,
  output logic             acc_clr,
  input  logic [WIDTH-1:0] acc_q
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      err_q    <= err_d;
      result_q <= result_d;
      rem_q    <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    err_d    = err_q;
    result_d = result_q;
    rem_d    = rem_q;
    acc_b    = '0;
    acc_e    = 1'b0;
    acc_s    = 1'b0;
    acc_clr  = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          a_d    = a;
          b_d    = b;
          cnt_d  = '0;
          quot_d = '0;
          err_d  = 1'b0;
          if (op == OP_DIV && b == '0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        acc_clr = 1'b1;
        if (op_q == OP_MUL) begin
          cnt_d   = a_q;
          state_d = ST_MUL_IT;
        end else begin
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        acc_b = a_q;
        acc_e = 1'b1;
        if (op_q == OP_DIV) begin
          quot_d  = '0;
          state_d = ST_DIV_IT;
        end else begin
          state_d = ST_OPB;
        end
      end
      ST_OPB: begin
        acc_b   = b_q;
        acc_e   = 1'b1;
        acc_s   = op_q[0];
        state_d = ST_DONE;
      end
      ST_MUL_IT: begin
        if (cnt_q != '0) begin
          acc_b = b_q;
          acc_e = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DIV_IT: begin
        // acc_q already reflects the previous cycle's subtract, so compare before subtracting again
        if (acc_q >= b_q) begin
          acc_b  = b_q;
          acc_e  = 1'b1;
          acc_s  = 1'b1;
          quot_d = quot_q + 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        if (err_q) begin
          result_d = '1;
          rem_d    = '0;
        end else if (op_q == OP_DIV) begin
          result_d = quot_q;
          rem_d    = acc_q;
        end else begin
          result_d = acc_q;
          rem_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The final accumulator update lands on the edge into DONE, so results bypass the hold registers there
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign result    = (state_q == ST_DONE) ? result_d : result_q;
  assign remainder = (state_q == ST_DONE) ? rem_d    : rem_q;

endmodule

// File: tb/tb_alu_accum_seq.sv
// Bench for alu_accum_seq wired to a behavioural accumulator; scoreboard of expected results and latencies.
module tb_alu_accum_seq;
  localparam int W = 8;

  logic         CLK, CLR, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, err, acc_e, acc_s, acc_clr;
  logic [W-1:0] result, remainder, acc_b, acc_q;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         err;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   act_cnt = 0;

  alu_accum_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .result(result), .remainder(remainder),
    .acc_b(acc_b), .acc_e(acc_e), .acc_s(acc_s), .acc_clr(acc_clr), .acc_q(acc_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Accumulator under the documented contract
  always @(posedge CLK or posedge CLR) begin
    if (CLR)          acc_q <= '0;
    else if (acc_clr) acc_q <= '0;
    else if (acc_e)   acc_q <= acc_s ? acc_q - acc_b : acc_q + acc_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.err = 1'b0;
    e.rem = '0;
    e.acc_cyc = 0;
    case (o)
      2'b00: begin e.res = x + y; e.lat = 4; end
      2'b01: begin e.res = x - y; e.lat = 4; end
      2'b10: begin e.res = W'(int'(x) * int'(y)); e.lat = 3 + int'(x); end
      default: begin
        if (y == 0) begin
          e.res = '1; e.err = 1'b1; e.lat = 1;
        end else begin
          e.res = x / y; e.rem = x % y; e.lat = 4 + int'(x / y);
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge CLK) begin
    if (!CLR) begin
      if (acc_e || acc_clr) act_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          last_exp = e;
          check("result", result, e.res);
          check("remainder", remainder, e.rem);
          check("err", err, e.err);
          check("busy_in_done", busy, 1'b1);
          check("latency", cyc - e.acc_cyc + 1, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    @(negedge CLK);
    start = 1'b1; op = o; a = x; b = y;
    e = model(o, x, y);
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 700);
    if (n >= 700) begin
      check("timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(o, x, y);
    wait_idle();
  endtask

  initial begin
    int snap;
    int n;
    CLR = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_remainder", remainder, 0);
    check("rst_acc_ctl", {acc_b, acc_e, acc_s, acc_clr}, 0);
    CLR = 1'b0;
    repeat (2) @(negedge CLK);

    run(2'b00, 8'd3, 8'd7);
    run(2'b01, 8'd3, 8'd7);
    run(2'b10, 8'd6, 8'd10);
    run(2'b10, 8'd20, 8'd13);
    run(2'b10, 8'd0, 8'd99);
    run(2'b11, 8'd60, 8'd12);
    run(2'b11, 8'd61, 8'd12);
    run(2'b11, 8'd5, 8'd12);

    snap = act_cnt;
    run(2'b11, 8'd60, 8'd0);
    check("div0_no_acc_activity", act_cnt - snap, 0);
    check("div0_err_held", err, 1);
    run(2'b00, 8'd1, 8'd1);
    check("err_cleared", err, 0);
    check("result_held", result, last_exp.res);

    for (int i = 0; i < 6; i++) begin
      logic [1:0] ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if (ro == 2'b10) ra = W'($urandom_range(0, 30));
      if (ro == 2'b11 && i == 5) rb = '0;
      run(ro, ra, rb);
    end

    // Start pulsed mid-MUL must be ignored
    issue(2'b10, 8'd6, 8'd10);
    repeat (3) @(negedge CLK);
    start = 1'b1; op = 2'b00; a = 8'd9; b = 8'd9;
    @(negedge CLK);
    start = 1'b0;
    wait_idle();
    check("mid_start_ignored", result, 8'd60);
    repeat (3) @(negedge CLK);
    check("no_extra_done", busy, 0);

    // Held start: three back-to-back ops, one done each
    @(negedge CLK);
    start = 1'b1; op = 2'b00; a = 8'd5; b = 8'd6;
    begin
      exp_t e;
      e = model(2'b00, 8'd5, 8'd6);
      e.acc_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge CLK);
        n++;
      end while (!done && n < 50);
      if (!done) check("held_timeout", 32'd0, 32'd1);
      if (k < 2) begin
        exp_t e;
        a = a + 8'd10;
        e = model(2'b00, a, 8'd6);
        e.acc_cyc = cyc + 2;
        exp_q.push_back(e);
      end else begin
        start = 1'b0;
      end
    end
    wait_idle();
    check("held_last_result", result, 8'd31);

    // Asynchronous CLR during MUL iterations
    issue(2'b10, 8'd50, 8'd1);
    repeat (10) @(negedge CLK);
    #2 CLR = 1'b1;
    #1;
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_result", result, 0);
    check("clr_acc_ctl", {acc_b, acc_e, acc_s, acc_clr}, 0);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    repeat (2) @(negedge CLK);
    run(2'b00, 8'd1, 8'd2);
    check("post_clr_add", result, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
